game_score_ctrl: RTL and testbench

Session controller for one Sudoku round: it runs the elapsed-seconds timer from a clock prescaler and sequences start, pause, solve, abort and timeout. On solve it computes the round score with a multi-cycle serial divider, so the design needs no combinational divide. It also keeps the best score since reset. It sits between the game FSM (start/solved/abort/pause strobes) and the display/scoreboard logic.

---
 rtl/game_pkg.sv | 17 +
 rtl/score_divider.sv | 53 +++++
 rtl/game_score_ctrl.sv | 147 ++++++++++++++
 tb/tb_game_score_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and default round constants for the score controller
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUNNING,
      ST_PAUSED,
      ST_SCORING,
      ST_DONE
   } state_t;

   localparam int DEFAULT_TIME_LIMIT = 600;
   localparam int DEFAULT_GRACE      = 60;
   localparam int DEFAULT_MAX_SCORE  = 100;
   localparam int SCORE_DEN          = DEFAULT_TIME_LIMIT - DEFAULT_GRACE;

endpackage

// File: rtl/score_divider.sv
// rtl/score_divider.sv - 16-cycle restoring divider, 16-bit numerator by 10-bit denominator
module score_divider #(
   parameter int QW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [15:0]   num,
   input  logic [9:0]    den,
   output logic          done,
   output logic [QW-1:0] quotient
);

   logic [15:0] quo;
   logic [9:0]  rem;
   logic [4:0]  cnt;
   logic        active;

   // quo shifts the numerator out MSB-first while quotient bits shift in at the LSB
   always_ff @(posedge clk) begin
      if (reset) begin
         quo    <= '0;
         rem    <= '0;
         cnt    <= '0;
         active <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            quo    <= num;
            rem    <= '0;
            cnt    <= 5'd16;
            active <= 1'b1;
         end else if (active) begin
            if ({rem, quo[15]} >= {1'b0, den}) begin
               rem <= 10'({rem, quo[15]} - {1'b0, den});
               quo <= {quo[14:0], 1'b1};
            end else begin
               rem <= {rem[8:0], quo[15]};
               quo <= {quo[14:0], 1'b0};
            end
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo[QW-1:0];

endmodule

// File: rtl/game_score_ctrl.sv
// rtl/game_score_ctrl.sv - round timer, state sequencing, scoring and best-score tracking
module game_score_ctrl
   import game_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int TIME_LIMIT    = DEFAULT_TIME_LIMIT,
   parameter int GRACE         = DEFAULT_GRACE,
   parameter int MAX_SCORE     = DEFAULT_MAX_SCORE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        solved,
   input  logic        abort,
   output logic [10:0] timer,
   output logic [6:0]  score,
   output logic        score_valid,
   output logic [6:0]  best_score,
   output logic        running,
   output logic        busy,
   output logic        timed_out
);

   localparam int              PW         = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [10:0]     LAST_SEC   = 11'(TIME_LIMIT - 1);
   localparam logic [10:0]     GRACE_T    = 11'(GRACE);
   localparam logic [9:0]      DEN        = 10'(TIME_LIMIT - GRACE);

   state_t        state, state_next;
   logic [PW-1:0] presc;
   logic          tick;
   logic          div_start;
   logic          div_done;
   logic [6:0]    div_q;
   logic [6:0]    score_new;
   logic [15:0]   num;

   assign tick      = (presc == PRESC_LAST);
   assign num       = (timer > GRACE_T) ? (16'(timer) - 16'(GRACE)) * 16'(MAX_SCORE) : 16'd0;
   assign score_new = 7'(MAX_SCORE) - div_q;
   assign running   = (state == ST_RUNNING) || (state == ST_PAUSED);
   assign busy      = (state == ST_SCORING);

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // solved outranks the tick, so a coincident solve scores the pre-tick time
   always_comb begin
      state_next = state;
      div_start  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start)
               state_next = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (abort)
               state_next = ST_IDLE;
            else if (solved) begin
               state_next = ST_SCORING;
               div_start  = 1'b1;
            end else if (tick && (timer == LAST_SEC))
               state_next = ST_DONE;
            else if (pause)
               state_next = ST_PAUSED;
         end
         ST_PAUSED: begin
            if (abort)
               state_next = ST_IDLE;
            else if (!pause)
               state_next = ST_RUNNING;
         end
         ST_SCORING: begin
            if (abort)
               state_next = ST_IDLE;
            else if (div_done)
               state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer       <= '0;
         presc       <= '0;
         score       <= '0;
         score_valid <= 1'b0;
         best_score  <= '0;
         timed_out   <= 1'b0;
      end else begin
         score_valid <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  timer     <= '0;
                  presc     <= '0;
                  timed_out <= 1'b0;
               end
            end
            ST_RUNNING: begin
               if (!abort && !solved) begin
                  if (tick) begin
                     presc <= '0;
                     timer <= timer + 11'd1;
                     if (timer == LAST_SEC) begin
                        score       <= '0;
                        score_valid <= 1'b1;
                        timed_out   <= 1'b1;
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
            end
            ST_SCORING: begin
               if (!abort && div_done) begin
                  score       <= score_new;
                  score_valid <= 1'b1;
                  if (score_new > best_score)
                     best_score <= score_new;
               end
            end
            default: ;
         endcase
      end
   end

   score_divider #(
      .QW(7)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .num      (num),
      .den      (DEN),
      .done     (div_done),
      .quotient (div_q)
   );

endmodule

// File: tb/tb_game_score_ctrl.sv
// tb/tb_game_score_ctrl.sv - scoreboard bench for game_score_ctrl with a 4-tick second
module tb_game_score_ctrl;

   localparam int TPS = 4;

   logic        clk = 1'b0;
   logic        reset, start, pause, solved, abort;
   logic [10:0] timer;
   logic [6:0]  score, best_score;
   logic        score_valid, running, busy, timed_out;

   typedef struct {
      int score;
      int best;
      int to;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   m_best   = 0;

   game_score_ctrl #(
      .TICKS_PER_SEC (TPS),
      .TIME_LIMIT    (600),
      .GRACE         (60),
      .MAX_SCORE     (100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pause       (pause),
      .solved      (solved),
      .abort       (abort),
      .timer       (timer),
      .score       (score),
      .score_valid (score_valid),
      .best_score  (best_score),
      .running     (running),
      .busy        (busy),
      .timed_out   (timed_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs == expv)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
   endtask

   function automatic int exp_score(input int t);
      if (t <= 60)
         return 100;
      return 100 - ((t - 60) * 100) / 540;
   endfunction

   always @(negedge clk) begin
      if (score_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_score_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("score", int'(score), e.score);
            check("best_score", int'(best_score), e.best);
            check("timed_out", int'(timed_out), e.to);
            check("valid_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_running", int'(running), 1);
      check("start_timer", int'(timer), 0);
   endtask

   task automatic wait_timer(input int t);
      int n = 0;
      while (int'(timer) != t && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("timer_reach", int'(timer), t);
   endtask

   task automatic solve_now(input int t);
      int s = exp_score(t);
      if (s > m_best)
         m_best = s;
      sb.push_back('{s, m_best, 0, cyc + 18});
      solved = 1'b1;
      @(negedge clk);
      solved = 1'b0;
      check("busy_after_solve", int'(busy), 1);
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("sb_drained", sb.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      pause  = 1'b0;
      solved = 1'b0;
      abort  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_timer", int'(timer), 0);
      check("rst_score", int'(score), 0);
      check("rst_best", int'(best_score), 0);
      check("rst_valid", int'(score_valid), 0);
      check("rst_running", int'(running), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_timed_out", int'(timed_out), 0);

      // round inside grace
      do_start();
      wait_timer(45);
      solve_now(45);
      drain(40);

      // mid-range score, best kept from the first round
      do_start();
      check("score_held_on_start", int'(score), 100);
      wait_timer(330);
      solve_now(330);
      drain(40);

      // timeout
      do_start();
      sb.push_back('{0, m_best, 1, cyc + 600 * TPS});
      drain(3000);
      check("timeout_timer", int'(timer), 600);
      check("timeout_running", int'(running), 0);
      check("timeout_flag_held", int'(timed_out), 1);

      // pause freezes the timer and masks solved
      do_start();
      check("start_clears_timed_out", int'(timed_out), 0);
      wait_timer(50);
      pause = 1'b1;
      for (int i = 0; i < 40; i++) begin
         solved = (i == 20);
         @(negedge clk);
      end
      solved = 1'b0;
      check("pause_timer_frozen", int'(timer), 50);
      check("pause_running", int'(running), 1);
      check("pause_no_busy", int'(busy), 0);
      pause = 1'b0;
      wait_timer(120);
      solve_now(120);
      drain(40);

      // abort during scoring
      do_start();
      wait_timer(200);
      solved = 1'b1;
      @(negedge clk);
      solved = 1'b0;
      check("abort_busy_before", int'(busy), 1);
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_running", int'(running), 0);
      repeat (25) @(negedge clk);
      check("abort_score_kept", int'(score), 89);
      check("abort_best_kept", int'(best_score), 100);
      check("abort_timer_held", int'(timer), 200);

      // solved on the same edge as a tick
      do_start();
      wait_timer(119);
      repeat (TPS - 1) @(negedge clk);
      solve_now(119);
      drain(40);
      check("coincident_timer", int'(timer), 119);

      // reset mid-round
      do_start();
      wait_timer(10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_best = 0;
      check("mid_rst_timer", int'(timer), 0);
      check("mid_rst_score", int'(score), 0);
      check("mid_rst_best", int'(best_score), 0);
      check("mid_rst_running", int'(running), 0);
      check("mid_rst_timed_out", int'(timed_out), 0);
      do_start();
      wait_timer(3);
      solve_now(3);
      drain(40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
